// File: rtl/csr_scan_controller.sv
// csr_scan_controller
//
// Purpose
//   Sequences the scan chain of the control/status register bank so the
//   whole bank can be loaded (and optionally read back) a byte at a time
//   from a byte-wide host port. Each accepted byte is shifted into the
//   chain LSB-first over 8 consecutive clocks. With readback, the bits
//   leaving the tail of the chain are reassembled into bytes and offered
//   on a handshaked output. processor_enable is held low for the whole
//   transaction so the bank is never clocked functionally mid-scan.
//
// Configuration
//   CSR_SCAN_READBACK_EN  defined   : capture register and DRAIN state
//                                     present; bytes returned on out_*.
//                         undefined : no readback; out_valid/out_data tied
//                                     to 0, out_ready and scan_out unused.
//
// Parameters
//   CHAIN_LEN  total chain length in bits, nonzero multiple of 8
//   CNT_W      bit counter width, 2**CNT_W > CHAIN_LEN
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   start             begin a transaction (sampled in IDLE only)
//   run_req           host wants the processor running when idle
//   in_valid/in_ready/in_data     byte input handshake
//   out_valid/out_ready/out_data  captured byte output handshake
//   scan_enable, scan_in, scan_out  scan chain pins of the bank
//   processor_enable  bank functional enable (run_req gated by IDLE)
//   busy              any state other than IDLE
//   done              one-cycle pulse in FINISH
//   state_dbg         current FSM state encoding, for observation
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both 1. ready/valid driven by this block depend on state only,
// never on the partner's valid/ready. A presented out_data is held stable
// until it is accepted.

module csr_scan_controller #(
   parameter int CHAIN_LEN = 64,
   parameter int CNT_W     = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       run_req,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   input  logic       out_ready,
   output logic       scan_enable,
   output logic       scan_in,
   input  logic       scan_out,
   output logic       processor_enable,
   output logic       busy,
   output logic       done,
   output logic [2:0] state_dbg
);

   // Encodings are fixed so state_dbg reads the same in both builds.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      SHIFT  = 3'd2,
`ifdef CSR_SCAN_READBACK_EN
      DRAIN  = 3'd3,
`endif
      FINISH = 3'd4
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [CNT_W-1:0] bit_cnt;     // bits shifted in this transaction
   logic [2:0]       sub_cnt;     // bit position within current byte
   logic [7:0]       shift_byte;  // byte being shifted, bit 0 is next out

`ifdef CSR_SCAN_READBACK_EN
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CHAIN_LEN);
   logic [7:0] capture;           // bits collected from the chain tail
`else
   // Without readback the exit test happens on the last shift edge,
   // before the counter has taken its final increment.
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);
   logic unused_inputs;
   assign unused_inputs = ^{out_ready, scan_out};
`endif

   // ---------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------
   // Next-state logic and state-decoded outputs
   // ---------------------------------------------------------------
   always_comb begin
      state_nxt        = state;
      in_ready         = 1'b0;
      out_valid        = 1'b0;
      out_data         = 8'h00;
      scan_enable      = 1'b0;
      scan_in          = 1'b0;
      busy             = 1'b1;
      done             = 1'b0;
      processor_enable = 1'b0;

      case (state)
         IDLE: begin
            busy             = 1'b0;
            processor_enable = run_req;
            if (start) begin
               state_nxt = LOAD;
            end
         end

         LOAD: begin
            in_ready = 1'b1;
            // in_ready is 1 here, so in_valid alone completes the transfer.
            if (in_valid) begin
               state_nxt = SHIFT;
            end
         end

         SHIFT: begin
            scan_enable = 1'b1;
            scan_in     = shift_byte[0];
            if (sub_cnt == 3'd7) begin
`ifdef CSR_SCAN_READBACK_EN
               state_nxt = DRAIN;
`else
               state_nxt = (bit_cnt == LAST_CNT) ? FINISH : LOAD;
`endif
            end
         end

`ifdef CSR_SCAN_READBACK_EN
         DRAIN: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_nxt = (bit_cnt == FULL_CNT) ? FINISH : LOAD;
            end
         end
`endif

         FINISH: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase

`ifdef CSR_SCAN_READBACK_EN
      // capture only moves during SHIFT, so it is stable throughout DRAIN
      // and is 0 out of reset.
      out_data = capture;
`endif
   end

   assign state_dbg = state;

   // ---------------------------------------------------------------
   // Datapath: counters, shift byte, capture
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt    <= '0;
         sub_cnt    <= 3'd0;
         shift_byte <= 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  bit_cnt <= '0;
               end
            end
            LOAD: begin
               if (in_valid) begin
                  shift_byte <= in_data;
                  sub_cnt    <= 3'd0;
               end
            end
            SHIFT: begin
               shift_byte <= {1'b0, shift_byte[7:1]};
               sub_cnt    <= sub_cnt + 3'd1;
               bit_cnt    <= bit_cnt + CNT_W'(1);
            end
            default: begin
            end
         endcase
      end
   end

`ifdef CSR_SCAN_READBACK_EN
   // First bit out of the chain ends up in bit 0 after 8 shifts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         capture <= 8'h00;
      end else if (state == SHIFT) begin
         capture <= {scan_out, capture[7:1]};
      end
   end
`endif

endmodule

// File: doc/csr_scan_controller.md
# csr_scan_controller

Sequences the scan chain of the control/status register bank so that the whole bank can be loaded and read back a byte at a time. It sits between a byte-wide host port (debug/loader) and the bank's scan_enable, scan_in and scan_out pins. It also gates the bank's processor_enable while a scan transaction is in progress. Each byte written is shifted in LSB-first; the bits displaced out of the chain are reassembled into bytes and returned on a handshaked output.

## Interface
Parameters:
- CHAIN_LEN, 64, total scan-chain length in bits; must be a nonzero multiple of 8.
- CNT_W, 7, width of the bit counter; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a scan transaction; sampled only in IDLE.
- run_req  input  1  host wants the processor running when not scanning.
- in_valid  input  1  in_data holds a byte to shift in.
- in_data  input  8  byte to shift in, bit 0 first.
- in_ready  output  1  controller accepts a byte this cycle.
- out_valid  output  1  out_data holds a captured byte.
- out_data  output  8  captured byte; first bit out of the chain is bit 0.
- out_ready  input  1  host accepts out_data this cycle.
- scan_enable  output  1  drives the bank's scan_enable.
- scan_in  output  1  drives the head of the chain.
- scan_out  input  1  tail of the chain.
- processor_enable  output  1  drives the bank's processor_enable.
- busy  output  1  transaction in progress (all states except IDLE).
- done  output  1  one-cycle pulse at end of transaction.

## Operation
- FSM states: IDLE, LOAD, SHIFT, DRAIN, FINISH. Every output decodes from registered state only.
- IDLE:
  - in_ready, out_valid, scan_enable, busy and done are all 0.
  - processor_enable = run_req.
  - start=1 at an edge -> LOAD; bit counter cleared.
- LOAD:
  - in_ready=1.
  - in_valid & in_ready at an edge latches in_data into the shift byte, clears the 3-bit sub-counter -> SHIFT.
  - in_valid=0 stalls with scan_enable=0, so the chain holds.
- SHIFT:
  - scan_enable=1; scan_in = shift byte bit 0.
  - At each edge:
    - shift byte >>= 1;
    - capture = {scan_out, capture[7:1]};
    - sub-counter and bit counter increment.
  - After the 8th edge -> DRAIN (readback) or the DRAIN exit decision directly (no readback).
- DRAIN:
  - out_valid=1; out_data = capture.
  - out_valid & out_ready at an edge:
    - bit counter == CHAIN_LEN -> FINISH;
    - otherwise -> LOAD.
  - out_ready=0 stalls; capture and out_data are held stable while out_valid=1.
- FINISH: done=1 for exactly one cycle -> IDLE.
- processor_enable = 0 in every state except IDLE; run_req is ignored while busy.
- scan_in = 0 whenever scan_enable=0.
- Boundary rules:
  - start in any non-IDLE state is ignored; no restart, no queueing.
  - in_valid in IDLE/SHIFT/DRAIN/FINISH is ignored; no byte is consumed.
  - Bit counter never exceeds CHAIN_LEN; exactly CHAIN_LEN/8 bytes are accepted per transaction.
  - rst asserted mid-transaction:
    - state -> IDLE; counters, shift byte and capture -> 0;
    - scan_enable drops immediately (async);
    - the chain keeps whatever was partially shifted; no restore is attempted.
- Reset values: state IDLE, all counters 0, shift byte 0, capture 0.
  - Outputs in_ready, out_valid, out_data, scan_enable, scan_in, busy, done = 0.
  - processor_enable = run_req.

## Timing
- start sampled at edge N -> LOAD, busy=1, processor_enable=0 from cycle N+1.
- Byte accepted at edge M -> scan_enable=1 for exactly cycles M+1..M+8, i.e. 8 consecutive edges with no bubbles.
- out_valid rises the cycle after the 8th shift edge.
- Minimum cost with readback, no stalls: 10 cycles per byte (1 LOAD, 8 SHIFT, 1 DRAIN).
  - CHAIN_LEN=64: start edge to done cycle = 81 cycles.
- done is asserted in the cycle before processor_enable may return high.

## Configuration
- CSR_SCAN_READBACK_EN defined:
  - capture register and DRAIN state are present, behaving as above.
- CSR_SCAN_READBACK_EN undefined:
  - no capture register and no DRAIN state;
  - out_valid and out_data are tied to 0; out_ready and scan_out are ignored;
  - after the 8th shift edge the FSM goes to FINISH if the bit counter == CHAIN_LEN, else LOAD;
  - cost is 9 cycles per byte, 73 cycles for CHAIN_LEN=64.

## Test plan
- Reset then idle:
  - run_req=1 -> processor_enable=1; busy, scan_enable and in_ready = 0.
  - start=1 -> processor_enable=0 next cycle.
- Full load, CHAIN_LEN=64, bytes 0x01..0x08 with out_ready=1:
  - scan_in sequence is 1,0,0,0,0,0,0,0, then 0,1,0,...;
  - 64 scan_enable cycles in total; done pulses once; busy falls.
- Readback, chain model preloaded with 0xA5 per byte:
  - eight out bytes 0xA5 in order;
  - a second transaction returns the 0x01..0x08 bytes shifted in by the first.
- Back-pressure:
  - in_valid low for 5 cycles mid-transaction, and out_ready low for 3 cycles in DRAIN;
  - scan_enable stays 0 during both stalls and out_data stays stable;
  - final chain contents are identical to the unstalled run.
- start pulsed during SHIFT -> ignored; exactly 8 bytes accepted; only one done pulse.
- rst asserted on the 4th SHIFT cycle:
  - scan_enable=0 the same cycle; state IDLE;
  - a subsequent start runs a clean full transaction.
